round_controller: RTL

Game-flow sequencer for the fencing display pipeline. It owns the match state: start screen, per-round 3-2-1 countdown, fight, round result, match result. Its registered mode outputs drive the display compositor's start-screen select and fight enable, and the health reload of both players. It consumes the decoded IR remote code, the per-frame `nf_in` pulse and both health values.

---
 rtl/round_controller.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/round_controller.sv
// Match-flow sequencer: idle screen, 3-2-1 countdown, fight, round result, match result.
// Optional pause state in FIGHT is built when the ROUND_PAUSE_EN macro is defined.
`timescale 1ns/1ps
module round_controller #(
    parameter int          FRAMES_PER_COUNT = 60,
    parameter int          RESULT_FRAMES    = 180,
    parameter int          ROUNDS_TO_WIN    = 2,
    parameter logic [31:0] IR_START_A       = 32'h20DF_5BA4,
    parameter logic [31:0] IR_START_B       = 32'h20DF_5AA5,
    parameter logic [31:0] IR_PAUSE         = 32'h20DF_10EF
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        nf_in,
    input  logic [31:0] ir_in,
    input  logic        ir_valid_in,
    input  logic [2:0]  player_health_in,
    input  logic [2:0]  opponent_health_in,
    output logic [2:0]  state_out,
    output logic        start_screen_out,
    output logic        fight_active_out,
    output logic [1:0]  countdown_out,
    output logic [1:0]  winner_out,
    output logic [1:0]  player_rounds_out,
    output logic [1:0]  opponent_rounds_out,
    output logic        health_reset_out,
    output logic        match_over_out
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_FIGHT     = 3'd2,
        S_ROUND_END = 3'd3,
        S_MATCH_END = 3'd4
`ifdef ROUND_PAUSE_EN
        , S_PAUSE   = 3'd5
`endif
    } state_t;

    localparam logic [8:0] CD_LAST  = 9'(3 * FRAMES_PER_COUNT - 1);
    localparam logic [8:0] CD_TWO   = 9'(FRAMES_PER_COUNT);
    localparam logic [8:0] CD_ONE   = 9'(2 * FRAMES_PER_COUNT);
    localparam logic [8:0] RES_LAST = 9'(RESULT_FRAMES - 1);
    localparam logic [1:0] ROUNDS   = 2'(ROUNDS_TO_WIN);

    state_t     state, state_n;
    logic [8:0] frame_cnt, frame_cnt_n;
    logic [1:0] winner, winner_n;
    logic [1:0] p_rounds, p_rounds_n;
    logic [1:0] o_rounds, o_rounds_n;
    logic       health_reset, health_reset_n;
    logic       start_ev;
    logic       pause_ev;

    function automatic logic [1:0] sat_inc(input logic [1:0] x);
        return (x >= ROUNDS) ? ROUNDS : x + 2'd1;
    endfunction

    assign start_ev = ir_valid_in && ((ir_in == IR_START_A) || (ir_in == IR_START_B));
`ifdef ROUND_PAUSE_EN
    assign pause_ev = ir_valid_in && (ir_in == IR_PAUSE);
`else
    assign pause_ev = 1'b0;
`endif

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= S_IDLE;
            frame_cnt    <= '0;
            winner       <= '0;
            p_rounds     <= '0;
            o_rounds     <= '0;
            health_reset <= 1'b0;
        end else begin
            state        <= state_n;
            frame_cnt    <= frame_cnt_n;
            winner       <= winner_n;
            p_rounds     <= p_rounds_n;
            o_rounds     <= o_rounds_n;
            health_reset <= health_reset_n;
        end
    end

    always_comb begin
        state_n        = state;
        frame_cnt_n    = nf_in ? frame_cnt + 9'd1 : frame_cnt;
        winner_n       = winner;
        p_rounds_n     = p_rounds;
        o_rounds_n     = o_rounds;
        health_reset_n = 1'b0;

        // A start code overrides any frame event seen on the same cycle.
        if (start_ev) begin
            case (state)
                S_IDLE: begin
                    state_n        = S_COUNTDOWN;
                    winner_n       = '0;
                    p_rounds_n     = '0;
                    o_rounds_n     = '0;
                    health_reset_n = 1'b1;
                end
                S_MATCH_END: state_n = S_IDLE;
                default: begin
                    state_n    = S_IDLE;
                    winner_n   = '0;
                    p_rounds_n = '0;
                    o_rounds_n = '0;
                end
            endcase
        end else begin
            case (state)
                S_COUNTDOWN: begin
                    if (nf_in && frame_cnt == CD_LAST)
                        state_n = S_FIGHT;
                end
                S_FIGHT: begin
                    if (pause_ev) begin
`ifdef ROUND_PAUSE_EN
                        state_n = S_PAUSE;
`endif
                    end else if (nf_in) begin
                        if (player_health_in == '0 && opponent_health_in == '0) begin
                            winner_n = 2'd3;
                            state_n  = S_ROUND_END;
                        end else if (player_health_in == '0) begin
                            winner_n   = 2'd2;
                            o_rounds_n = sat_inc(o_rounds);
                            state_n    = S_ROUND_END;
                        end else if (opponent_health_in == '0) begin
                            winner_n   = 2'd1;
                            p_rounds_n = sat_inc(p_rounds);
                            state_n    = S_ROUND_END;
                        end
                    end
                end
                S_ROUND_END: begin
                    if (nf_in && frame_cnt == RES_LAST) begin
                        if (p_rounds == ROUNDS || o_rounds == ROUNDS) begin
                            state_n  = S_MATCH_END;
                            winner_n = (p_rounds == ROUNDS) ? 2'd1 : 2'd2;
                        end else begin
                            state_n        = S_COUNTDOWN;
                            health_reset_n = 1'b1;
                        end
                    end
                end
`ifdef ROUND_PAUSE_EN
                S_PAUSE: begin
                    if (pause_ev)
                        state_n = S_FIGHT;
                end
`endif
                default: ;
            endcase
        end

        if (state_n != state)
            frame_cnt_n = '0;
    end

    assign state_out           = state;
    assign start_screen_out    = (state == S_IDLE);
    assign fight_active_out    = (state == S_FIGHT);
    assign match_over_out      = (state == S_MATCH_END);
    assign winner_out          = winner;
    assign player_rounds_out   = p_rounds;
    assign opponent_rounds_out = o_rounds;
    assign health_reset_out    = health_reset;
    assign countdown_out       = (state != S_COUNTDOWN) ? 2'd0 :
                                 (frame_cnt < CD_TWO)   ? 2'd3 :
                                 (frame_cnt < CD_ONE)   ? 2'd2 : 2'd1;

endmodule
